// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared encodings and widths for the interrupt request controller.
package int_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int VEC_W  = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_MASK   = 2'd0;
    localparam logic [1:0] ADDR_PEND   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    // One configuration-port access as seen in a single cycle.
    typedef struct packed {
        logic              wr_en;
        logic [1:0]        add;
        logic [DATA_W-1:0] wr_dt;
    } cfg_req_t;

endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-index-wins priority encoder over the candidate sources.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [VEC_W-1:0]   idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: edge-latching interrupt controller with mask, priority pick and
// a REQ pulse that ends on int_ack or after PULSE_LEN un-stalled cycles.
// Optional feature macro: INT_CTRL_NEST_EN (one level of preemption in SERVICE).
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC   = 8,
    parameter int PULSE_LEN = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stallb,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               int_ack,
    input  logic               int_rti,
    input  logic               cfg_wr_en,
    input  logic [1:0]         cfg_add,
    input  logic [DATA_W-1:0]  cfg_wr_dt,
    output logic [DATA_W-1:0]  cfg_rd_dt,
    output logic               interrupt,
    output logic [VEC_W-1:0]   int_vec,
    output logic               int_busy
);

    state_t              state, state_nx;
    cfg_req_t            cfg;
    logic [NUM_SRC-1:0]  src_q, mask, pend, pend_nx, cand;
    logic [CNT_W-1:0]    cnt;
    logic                win_vld;
    logic [VEC_W-1:0]    win_idx;
    logic                issue, drop;
    logic [DATA_W-1:0]   rd_nx;
    logic                unused_wr_dt;
`ifdef INT_CTRL_NEST_EN
    logic                push, pop;
    logic                save_full;
    logic [VEC_W-1:0]    save_vec;
`endif

    assign cfg          = '{wr_en: cfg_wr_en, add: cfg_add, wr_dt: cfg_wr_dt};
    assign unused_wr_dt = ^cfg.wr_dt;
    assign cand         = pend & ~mask;
    assign int_busy     = (state != ST_IDLE);

    int_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
        .req   (cand),
        .valid (win_vld),
        .idx   (win_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next state plus the one-cycle issue/drop (and push/pop) strobes.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        drop     = 1'b0;
`ifdef INT_CTRL_NEST_EN
        push     = 1'b0;
        pop      = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (stallb && win_vld) begin
                    state_nx = ST_REQ;
                    issue    = 1'b1;
                end
            end
            ST_REQ: begin
                if (int_ack || (stallb && cnt == CNT_W'(PULSE_LEN - 1))) begin
                    state_nx = ST_SERVICE;
                    drop     = 1'b1;
                end
            end
            ST_SERVICE: begin
`ifdef INT_CTRL_NEST_EN
                // rti wins over a same-cycle preemption; a nested rti resumes the saved vector.
                if (int_rti && save_full) begin
                    pop = 1'b1;
                end else if (int_rti) begin
                    state_nx = ST_IDLE;
                end else if (stallb && win_vld && !save_full && win_idx < int_vec) begin
                    state_nx = ST_REQ;
                    issue    = 1'b1;
                    push     = 1'b1;
                end
`else
                if (int_rti) state_nx = ST_IDLE;
`endif
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Pending update: W1C and issue clear first, so a same-cycle new edge wins.
    always_comb begin
        pend_nx = pend;
        if (cfg.wr_en && cfg.add == ADDR_PEND) pend_nx = pend_nx & ~cfg.wr_dt[NUM_SRC-1:0];
        if (issue) pend_nx = pend_nx & ~(NUM_SRC'(1) << win_idx);
        pend_nx = pend_nx | (src_irq & ~src_q);
    end

    // Read mux; registered below so data appears one cycle after the address.
    always_comb begin
        rd_nx = '0;
        case (cfg.add)
            ADDR_MASK:   rd_nx = DATA_W'(mask);
            ADDR_PEND:   rd_nx = DATA_W'(pend);
`ifdef INT_CTRL_NEST_EN
            ADDR_STATUS: rd_nx = {9'b0, save_full, state, int_vec};
`else
            ADDR_STATUS: rd_nx = {10'b0, state, int_vec};
`endif
            default:     rd_nx = '0;
        endcase
    end

    // Datapath registers: edge capture, mask/pend, pulse counter, request outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q     <= '0;
            mask      <= '1;
            pend      <= '0;
            cnt       <= '0;
            interrupt <= 1'b0;
            int_vec   <= '0;
            cfg_rd_dt <= '0;
        end else begin
            src_q     <= src_irq;
            pend      <= pend_nx;
            cfg_rd_dt <= rd_nx;
            if (cfg.wr_en && cfg.add == ADDR_MASK) mask <= cfg.wr_dt[NUM_SRC-1:0];
            if (issue) begin
                interrupt <= 1'b1;
                int_vec   <= win_idx;
                cnt       <= '0;
            end else if (drop) begin
                interrupt <= 1'b0;
            end else if (state == ST_REQ && stallb) begin
                cnt <= cnt + CNT_W'(1);
            end
`ifdef INT_CTRL_NEST_EN
            if (pop) int_vec <= save_vec;
`endif
        end
    end

`ifdef INT_CTRL_NEST_EN
    // One-deep save register for the preempted vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            save_full <= 1'b0;
            save_vec  <= '0;
        end else if (push) begin
            save_full <= 1'b1;
            save_vec  <= int_vec;
        end else if (pop) begin
            save_full <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed test-plan scenarios plus randomized traffic, all checked
// cycle by cycle against a behavioural model of the controller.
module tb_int_ctrl;

    localparam int          NS    = 8;
    localparam int          PL    = 2;
    localparam logic [15:0] SRC_M = 16'h00FF;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stallb = 1'b1;
    logic [NS-1:0] src_irq = '0;
    logic          int_ack = 1'b0, int_rti = 1'b0, cfg_wr_en = 1'b0;
    logic [1:0]    cfg_add = 2'd0;
    logic [15:0]   cfg_wr_dt = 16'h0;
    logic [15:0]   cfg_rd_dt;
    logic          interrupt, int_busy;
    logic [3:0]    int_vec;

    int n_chk = 0, n_pass = 0;

    int_ctrl #(.NUM_SRC(NS), .PULSE_LEN(PL)) dut (
        .clk(clk), .reset(reset), .stallb(stallb), .src_irq(src_irq),
        .int_ack(int_ack), .int_rti(int_rti), .cfg_wr_en(cfg_wr_en),
        .cfg_add(cfg_add), .cfg_wr_dt(cfg_wr_dt), .cfg_rd_dt(cfg_rd_dt),
        .interrupt(interrupt), .int_vec(int_vec), .int_busy(int_busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 idle, 1 requesting, 2 servicing; m_left counts
    // down the un-stalled high cycles still owed to the current pulse.
    logic [15:0] m_mask = SRC_M, m_pend = '0, m_srcq = '0, m_rd = '0;
    int          m_ph = 0, m_left = 0;
    logic        m_int = 1'b0, m_svf = 1'b0;
    logic [3:0]  m_vec = '0, m_svv = '0;

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin : model
        logic [15:0] p, src;
        int          w;
        if (!reset) begin
            m_mask = SRC_M; m_pend = '0; m_srcq = '0; m_rd = '0;
            m_ph = 0; m_left = 0; m_int = 1'b0; m_svf = 1'b0; m_vec = '0; m_svv = '0;
        end else begin
            src = 16'(src_irq);
            case (cfg_add)
                2'd0:    m_rd = m_mask;
                2'd1:    m_rd = m_pend;
                2'd2:    m_rd = {9'd0, m_svf, 2'(m_ph), m_vec};
                default: m_rd = '0;
            endcase
            w = lowest(m_pend & ~m_mask);
            p = m_pend;
            if (cfg_wr_en && cfg_add == 2'd1) p = p & ~cfg_wr_dt;
            if (m_ph == 0) begin
                if (stallb && w >= 0) begin
                    m_ph = 1; m_int = 1'b1; m_vec = 4'(w); p[w] = 1'b0; m_left = PL;
                end
            end else if (m_ph == 1) begin
                if (!int_ack && stallb) m_left--;
                if (int_ack || m_left == 0) begin m_ph = 2; m_int = 1'b0; end
            end else begin
                if (int_rti) begin
                    if (m_svf) begin m_svf = 1'b0; m_vec = m_svv; end
                    else m_ph = 0;
                end
`ifdef INT_CTRL_NEST_EN
                else if (stallb && w >= 0 && !m_svf && w < int'(m_vec)) begin
                    m_svv = m_vec; m_svf = 1'b1;
                    m_ph = 1; m_int = 1'b1; m_vec = 4'(w); p[w] = 1'b0; m_left = PL;
                end
`endif
            end
            p = p | (src & ~m_srcq);
            m_pend = p & SRC_M;
            if (cfg_wr_en && cfg_add == 2'd0) m_mask = cfg_wr_dt & SRC_M;
            m_srcq = src;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // One clock; outputs compared to the model on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        chk("interrupt", interrupt, m_int);
        chk("int_vec", int_vec, m_vec);
        chk("int_busy", int_busy, m_ph != 0);
        chk("cfg_rd_dt", cfg_rd_dt, m_rd);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cfg_wr_en = 1'b1; cfg_add = a; cfg_wr_dt = d;
        cyc();
        cfg_wr_en = 1'b0;
    endtask

    // Mask everything, clear pending and retire any outstanding service.
    task automatic drain();
        src_irq = '0; int_ack = 1'b0; int_rti = 1'b0; stallb = 1'b1;
        wr(2'd0, 16'hFFFF);
        wr(2'd1, 16'hFFFF);
        for (int i = 0; i < 40; i++) begin
            if (m_ph == 0) break;
            int_rti = (m_ph == 2);
            cyc();
            int_rti = 1'b0;
        end
        chk("drain_idle", int_busy, 0);
    endtask

    initial begin : stim
        int n;
        // Reset state
        @(negedge clk);
        chk("rst_interrupt", interrupt, 0);
        chk("rst_vec", int_vec, 0);
        chk("rst_busy", int_busy, 0);
        chk("rst_rd", cfg_rd_dt, 0);
        reset = 1'b1;

        // Basic request, 2-cycle latency, PULSE_LEN-long pulse
        wr(2'd0, 16'hFFFE);
        src_irq = 8'h01;
        cyc(); chk("t1_lat", interrupt, 0);
        cyc(); chk("t1_hi1", interrupt, 1); chk("t1_vec", int_vec, 0);
        cyc(); chk("t1_hi2", interrupt, 1);
        cyc(); chk("t1_lo", interrupt, 0);
        cfg_add = 2'd1;
        cyc(); chk("t1_pend", cfg_rd_dt, 16'h0000);
        int_rti = 1'b1; cyc(); int_rti = 1'b0;
        cfg_add = 2'd2;
        cyc(); chk("t1_state", cfg_rd_dt[5:4], 0);

        // Simultaneous sources 3 and 5
        drain();
        wr(2'd0, 16'h0000);
        src_irq = 8'h28;
        cyc(); cyc();
        chk("t2_int", interrupt, 1); chk("t2_vec3", int_vec, 3);
        cfg_add = 2'd1;
        cyc(); chk("t2_pend", cfg_rd_dt, 16'h0020);
        cyc(); chk("t2_drop", interrupt, 0);
        int_rti = 1'b1; cyc(); int_rti = 1'b0;
        chk("t2_idle", int_busy, 0);
        cyc(); chk("t2_next", interrupt, 1); chk("t2_vec5", int_vec, 5);

        // Stall stretches the pulse
        drain();
        wr(2'd0, 16'h0000);
        src_irq = 8'h02;
        cyc(); cyc();
        n = int'(interrupt);
        stallb = 1'b0;
        repeat (4) begin cyc(); n += int'(interrupt); end
        stallb = 1'b1;
        repeat (4) begin cyc(); n += int'(interrupt); end
        chk("t3_stall_len", n, 6);

        // int_ack ends the pulse early
        drain();
        wr(2'd0, 16'h0000);
        src_irq = 8'h04;
        cyc(); cyc(); chk("t3_ack_hi", interrupt, 1);
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        chk("t3_ack_drop", interrupt, 0); chk("t3_ack_busy", int_busy, 1);

        // Masked source, unmask, set-beats-clear
        drain();
        wr(2'd0, 16'h0004);
        src_irq = 8'h04;
        repeat (3) cyc();
        chk("t4_masked", interrupt, 0);
        cfg_add = 2'd1;
        cyc(); chk("t4_pend", cfg_rd_dt, 16'h0004);
        wr(2'd0, 16'h0000); chk("t4_unmask_edge", interrupt, 0);
        cyc(); chk("t4_unmask_hi", interrupt, 1); chk("t4_vec", int_vec, 2);
        src_irq = 8'h00; cyc();
        src_irq = 8'h04; wr(2'd1, 16'h0004);
        cfg_add = 2'd1;
        cyc(); chk("t4_set_wins", cfg_rd_dt, 16'h0004);

        // Asynchronous reset mid-request
        drain();
        wr(2'd0, 16'h0000);
        src_irq = 8'h10;
        cyc(); cyc(); chk("t5_hi", interrupt, 1);
        src_irq = 8'h00;
        #2 reset = 1'b0;
        #1 chk("t5_async_int", interrupt, 0);
        chk("t5_async_busy", int_busy, 0);
        @(negedge clk);
        reset = 1'b1; cfg_add = 2'd0;
        cyc(); chk("t5_mask", cfg_rd_dt, 16'h00FF);
        cfg_add = 2'd1;
        cyc(); chk("t5_pend", cfg_rd_dt, 16'h0000);

`ifdef INT_CTRL_NEST_EN
        // Preemption and resume
        drain();
        wr(2'd0, 16'h0000);
        src_irq = 8'h10;
        repeat (4) cyc();
        chk("n_svc4", int_vec, 4); chk("n_svc_busy", int_busy, 1);
        src_irq = 8'h12;
        cyc(); cyc(); chk("n_pre_int", interrupt, 1); chk("n_pre_vec", int_vec, 1);
        cyc(); cyc();
        int_rti = 1'b1; cyc(); int_rti = 1'b0;
        chk("n_resume_vec", int_vec, 4); chk("n_resume_busy", int_busy, 1);
        int_rti = 1'b1; cyc(); int_rti = 1'b0;
        chk("n_idle", int_busy, 0);
`endif

        // Randomized traffic
        drain();
        for (int i = 0; i < 800; i++) begin
            src_irq   = src_irq ^ NS'($urandom & $urandom);
            stallb    = ($urandom_range(0, 7) != 0);
            int_ack   = ($urandom_range(0, 5) == 0);
            int_rti   = ($urandom_range(0, 4) == 0);
            cfg_wr_en = ($urandom_range(0, 7) == 0);
            cfg_add   = 2'($urandom);
            cfg_wr_dt = 16'($urandom & $urandom);
            cyc();
        end
        cfg_wr_en = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
